// File: rtl/ifetch_resp_if.sv
// ============================================================================
// Module      : ifetch_resp_if
// Description : Fetch request/response and backing-memory word port bundle
//               for ifetch_resp. The slave modport is the fetch block itself.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ifetch_resp_if;
  // Requester side
  logic        inst_re_i;
  logic [31:0] inst_raddr_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        hold_flag_i;
  logic [31:0] hold_addr_i;
  logic        inst_re_o;
  logic [63:0] inst_rdata_o;
  logic [31:0] inst_raddr_o;
  // Backing memory side
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output inst_re_i, inst_raddr_i, jump_flag_i, jump_addr_i,
           hold_flag_i, hold_addr_i, mem_ack_i, mem_rdata_i,
    input  inst_re_o, inst_rdata_o, inst_raddr_o, mem_req_o, mem_addr_o
  );

  modport slave (
    input  inst_re_i, inst_raddr_i, jump_flag_i, jump_addr_i,
           hold_flag_i, hold_addr_i, mem_ack_i, mem_rdata_i,
    output inst_re_o, inst_rdata_o, inst_raddr_o, mem_req_o, mem_addr_o
  );
endinterface

`default_nettype wire

// File: rtl/ifetch_resp.sv
// ============================================================================
// Module      : ifetch_resp
// Description : Doubleword instruction fetch via two 32-bit memory beats.
//               Optional 1-entry line buffer enabled by IFETCH_LINEBUF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_resp (
  input  logic          clk,
  input  logic          rst,
  ifetch_resp_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        cancel_q, cancel_d;
  logic [31:0] base_q, base_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] rdata_q, rdata_d;
  logic [31:0] raddr_q, raddr_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;

  logic        flush;
  logic        accept;
  logic        fill;
  logic        hit;
  logic [63:0] hit_data;
  logic [31:0] req_base;
  logic        unused_ok;

  assign flush    = bus.jump_flag_i | bus.hold_flag_i;
  assign req_base = {bus.inst_raddr_i[31:3], 3'b000};
  assign accept   = (state_q == IDLE) && bus.inst_re_i && !flush;

  // Redirect targets are resolved upstream; only the flags matter here.
  assign unused_ok = ^{bus.jump_addr_i, bus.hold_addr_i, bus.inst_raddr_i[2:0]};

`ifdef IFETCH_LINEBUF_EN
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_addr_q, buf_addr_d;
  logic [63:0] buf_data_q, buf_data_d;

  assign hit      = buf_valid_q && (buf_addr_q == req_base);
  assign hit_data = buf_data_q;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    if (fill) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = base_q;
      buf_data_d  = {bus.mem_rdata_i, lo_q};
    end
    // fence.i: any hold drops the entry, taking priority over a fill
    if (bus.hold_flag_i) begin
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= 32'd0;
      buf_data_q  <= 64'd0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = 64'd0;
`endif

  always_comb begin
    state_d    = state_q;
    cancel_d   = cancel_q;
    base_d     = base_q;
    lo_d       = lo_q;
    rdata_d    = rdata_q;
    raddr_d    = raddr_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fill       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          base_d   = req_base;
          cancel_d = 1'b0;
          if (hit) begin
            rdata_d = hit_data;
            raddr_d = req_base;
            state_d = RESP;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = req_base;
            state_d    = BEAT0;
          end
        end
      end

      BEAT0: begin
        if (flush) begin
          cancel_d = 1'b1;
        end
        if (bus.mem_ack_i) begin
          lo_d       = bus.mem_rdata_i;
          mem_addr_d = base_q + 32'd4;
          state_d    = BEAT1;
        end
      end

      BEAT1: begin
        // A flush coinciding with the final ack still cancels the response.
        if (flush) begin
          cancel_d = 1'b1;
        end
        if (bus.mem_ack_i) begin
          mem_req_d = 1'b0;
          if (!cancel_d) begin
            rdata_d = {bus.mem_rdata_i, lo_q};
            raddr_d = base_q;
            fill    = 1'b1;
            state_d = RESP;
          end else begin
            state_d = IDLE;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cancel_q   <= 1'b0;
      base_q     <= 32'd0;
      lo_q       <= 32'd0;
      rdata_q    <= 64'd0;
      raddr_q    <= 32'd0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cancel_q   <= cancel_d;
      base_q     <= base_d;
      lo_q       <= lo_d;
      rdata_q    <= rdata_d;
      raddr_q    <= raddr_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign bus.inst_re_o    = (state_q == RESP) && !flush;
  assign bus.inst_rdata_o = rdata_q;
  assign bus.inst_raddr_o = raddr_q;
  assign bus.mem_req_o    = mem_req_q;
  assign bus.mem_addr_o   = mem_addr_q;

endmodule

`default_nettype wire
